// File: rtl/hdc_feature_pkg.sv
// Shared sizing and write-FSM encoding for the HDC feature packer.
// Defaults come from `TOTAL_NUM_CHANNEL / `CHANNEL_WIDTH when the build defines them.
`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 214
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 2
`endif

package hdc_feature_pkg;

    // Index width never collapses to zero bits, even for single-channel frames.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_CHANNEL   = `TOTAL_NUM_CHANNEL;
    localparam int CHANNEL_WIDTH = `CHANNEL_WIDTH;
    localparam int FRAME_WIDTH   = NUM_CHANNEL * CHANNEL_WIDTH;
    localparam int IDX_WIDTH     = idx_width(NUM_CHANNEL);

    typedef enum logic {
        COLLECT = 1'b0,
        RESYNC  = 1'b1
    } wr_state_e;

endpackage

// File: rtl/hdc_frame_buf.sv
// One frame of channel features with indexed per-channel write and a full flag.
module hdc_frame_buf #(
    parameter int NUM_CHANNEL   = 4,
    parameter int CHANNEL_WIDTH = 2,
    parameter int IDX_WIDTH     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_en,
    input  logic [IDX_WIDTH-1:0]                 wr_idx,
    input  logic [CHANNEL_WIDTH-1:0]             wr_data,
    input  logic                                 set_full,
    input  logic                                 clr_full,
    output logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] frame,
    output logic                                 full
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NUM_CHANNEL; k++) begin
                if (wr_idx == IDX_WIDTH'(k))
                    frame[k*CHANNEL_WIDTH +: CHANNEL_WIDTH] <= wr_data;
            end
        end
    end

    // The packer never sets and clears the same buffer in one cycle; set wins if it did.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            full <= 1'b0;
        else if (set_full)
            full <= 1'b1;
        else if (clr_full)
            full <= 1'b0;
    end

endmodule

// File: rtl/hdc_feature_packer.sv
// Serial channel beats -> ping-pong framed wide word for hdc_sensor_fusion.
// Optional FEATURE_PACKER_STATS_EN adds saturating frames_out / frames_dropped counters.
module hdc_feature_packer #(
    parameter int NUM_CHANNEL   = hdc_feature_pkg::NUM_CHANNEL,
    parameter int CHANNEL_WIDTH = hdc_feature_pkg::CHANNEL_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [CHANNEL_WIDTH-1:0]             ch_data,
    input  logic                                 ch_valid,
    input  logic                                 ch_last,
    output logic                                 ch_ready,
    output logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
    output logic                                 fin_valid,
    input  logic                                 fin_ready,
    output logic                                 frame_err,
`ifdef FEATURE_PACKER_STATS_EN
    output logic [31:0]                          frames_out,
    output logic [15:0]                          frames_dropped,
`endif
    input  logic                                 err_clr
);
    import hdc_feature_pkg::*;

    localparam int FRAME_WIDTH = NUM_CHANNEL * CHANNEL_WIDTH;
    localparam int IDX_WIDTH   = idx_width(NUM_CHANNEL);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CHANNEL - 1);

    wr_state_e            state_q, state_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic                 wr_ptr_q, rd_ptr_q, ch_ready_q, frame_err_q;
    logic [1:0]           full, set_full, clr_full, wr_en, next_full;
    logic [FRAME_WIDTH-1:0] frame [2];
    logic                 accept, fire, err_set, frame_done;

    assign accept = ch_valid & ch_ready_q;
    assign fire   = full[rd_ptr_q] & fin_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_set    = 1'b0;
        frame_done = 1'b0;
        wr_en      = 2'b00;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    wr_en[wr_ptr_q] = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (ch_last) begin
                            frame_done = 1'b1;
                        end else begin
                            err_set = 1'b1;
                            state_d = RESYNC;
                        end
                    end else if (ch_last) begin
                        idx_d   = '0;
                        err_set = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            RESYNC: begin
                if (accept && ch_last) begin
                    state_d = COLLECT;
                    idx_d   = '0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign set_full  = frame_done ? (wr_ptr_q ? 2'b10 : 2'b01) : 2'b00;
    assign clr_full  = fire       ? (rd_ptr_q ? 2'b10 : 2'b01) : 2'b00;
    assign next_full = (full | set_full) & ~clr_full;

    // ch_ready is registered from the post-update buffer state so it never depends on ch_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            ch_ready_q  <= 1'b1;
            frame_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_ptr_q   <= wr_ptr_q ^ frame_done;
            rd_ptr_q   <= rd_ptr_q ^ fire;
            ch_ready_q <= ~(&next_full);
            if (err_set)
                frame_err_q <= 1'b1;
            else if (err_clr)
                frame_err_q <= 1'b0;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_buf
        hdc_frame_buf #(
            .NUM_CHANNEL  (NUM_CHANNEL),
            .CHANNEL_WIDTH(CHANNEL_WIDTH),
            .IDX_WIDTH    (IDX_WIDTH)
        ) u_buf (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[b]),
            .wr_idx  (idx_q),
            .wr_data (ch_data),
            .set_full(set_full[b]),
            .clr_full(clr_full[b]),
            .frame   (frame[b]),
            .full    (full[b])
        );
    end

    assign ch_ready     = ch_ready_q;
    assign fin_valid    = full[rd_ptr_q];
    assign features_top = frame[rd_ptr_q];
    assign frame_err    = frame_err_q;

`ifdef FEATURE_PACKER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_out     <= '0;
            frames_dropped <= '0;
        end else begin
            if (fire && frames_out != '1)
                frames_out <= frames_out + 1'b1;
            if (err_set && frames_dropped != '1)
                frames_dropped <= frames_dropped + 1'b1;
        end
    end
`endif

endmodule
